// File: rtl/winner_announcer.sv
// Captures a drawn winner, rejects invalid or recently seen ids, and announces
// accepted winners on a blinking 2-digit multiplexed 7-segment display until acknowledged.
module winner_announcer #(
  parameter int HIST_DEPTH    = 4,
  parameter int BLINK_HALF    = 4,
  parameter int BLINK_TOGGLES = 6,
  parameter int MUX_CYCLES    = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [4:0]                      winner,
  input  logic                            win_valid,
  input  logic [4:0]                      entries,
  input  logic                            ack,
  input  logic                            clear_hist,
  output logic [4:0]                      shown_id,
  output logic                            busy,
  output logic                            announcing,
  output logic                            reject,
  output logic [$clog2(HIST_DEPTH+1)-1:0] hist_count,
  output logic [6:0]                      seg,
  output logic [1:0]                      an
);

  localparam int CW = $clog2(HIST_DEPTH + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam int TW = $clog2(BLINK_TOGGLES + 1);
  localparam int MW = $clog2(MUX_CYCLES + 1);
  localparam logic [CW-1:0] HIST_FULL  = CW'(HIST_DEPTH);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [TW-1:0] TOG_LAST   = TW'(BLINK_TOGGLES - 1);
  localparam logic [MW-1:0] MUX_LAST   = MW'(MUX_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CHECK, ANNOUNCE, HOLD} state_t;

  state_t                state_q, state_d;
  logic [4:0]            cap_q, cap_d;
  logic                  wv_q;
  logic [4:0]            hist_q [HIST_DEPTH];
  logic [4:0]            hist_d [HIST_DEPTH];
  logic [HIST_DEPTH-1:0] hist_vld_q, hist_vld_d;
  logic [CW-1:0]         count_d;
  logic [BW-1:0]         blink_q, blink_d;
  logic [TW-1:0]         tog_q, tog_d;
  logic [MW-1:0]         mux_q, mux_d;
  logic                  digit_q, digit_d;
  logic [4:0]            shown_d;
  logic                  reject_d, busy_d, ann_d, disp_on;
  logic [6:0]            seg_d;
  logic [1:0]            an_d;
  logic [1:0]            tens;
  logic [3:0]            units;
  logic                  dup, cap_ok, edge_det;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h3F;
      4'd1:    seg_code = 7'h06;
      4'd2:    seg_code = 7'h5B;
      4'd3:    seg_code = 7'h4F;
      4'd4:    seg_code = 7'h66;
      4'd5:    seg_code = 7'h6D;
      4'd6:    seg_code = 7'h7D;
      4'd7:    seg_code = 7'h07;
      4'd8:    seg_code = 7'h7F;
      4'd9:    seg_code = 7'h6F;
      default: seg_code = 7'h00;
    endcase
  endfunction

  assign edge_det = win_valid & ~wv_q;

  // Unknown bits in the captured id are treated as an invalid draw.
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < HIST_DEPTH; i++) begin
      if (hist_vld_q[i] && (hist_q[i] == cap_q)) dup = 1'b1;
    end
    cap_ok = !$isunknown(cap_q) && (cap_q != 5'd0) && (cap_q < entries) && !dup;
  end

  always_comb begin
    state_d    = state_q;
    cap_d      = cap_q;
    hist_d     = hist_q;
    hist_vld_d = hist_vld_q;
    count_d    = hist_count;
    blink_d    = blink_q;
    tog_d      = tog_q;
    shown_d    = shown_id;
    reject_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_hist) begin
          hist_vld_d = '0;
          count_d    = '0;
        end
        if (edge_det) begin
          cap_d   = winner;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (cap_ok) begin
          for (int i = HIST_DEPTH - 1; i > 0; i--) begin
            hist_d[i]     = hist_q[i-1];
            hist_vld_d[i] = hist_vld_q[i-1];
          end
          hist_d[0]     = cap_q;
          hist_vld_d[0] = 1'b1;
          if (hist_count != HIST_FULL) count_d = hist_count + 1'b1;
          shown_d = cap_q;
          blink_d = '0;
          tog_d   = '0;
          state_d = ANNOUNCE;
        end else begin
          reject_d = 1'b1;
          state_d  = IDLE;
        end
      end
      ANNOUNCE: begin
        if (blink_q == BLINK_LAST) begin
          blink_d = '0;
          if (tog_q == TOG_LAST) begin
            tog_d   = '0;
            state_d = HOLD;
          end else begin
            tog_d = tog_q + 1'b1;
          end
        end else begin
          blink_d = blink_q + 1'b1;
        end
      end
      HOLD: begin
        if (ack) begin
          state_d = IDLE;
          shown_d = 5'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Display is derived from next-cycle values so the registered outputs line up with the state.
  always_comb begin
    busy_d  = (state_d != IDLE);
    ann_d   = (state_d == ANNOUNCE);
    mux_d   = '0;
    digit_d = 1'b0;
    if (busy_d && (state_q != IDLE)) begin
      if (mux_q == MUX_LAST) begin
        mux_d   = '0;
        digit_d = ~digit_q;
      end else begin
        mux_d   = mux_q + 1'b1;
        digit_d = digit_q;
      end
    end
    if (shown_d >= 5'd30) begin
      tens  = 2'd3;
      units = 4'(shown_d - 5'd30);
    end else if (shown_d >= 5'd20) begin
      tens  = 2'd2;
      units = 4'(shown_d - 5'd20);
    end else if (shown_d >= 5'd10) begin
      tens  = 2'd1;
      units = 4'(shown_d - 5'd10);
    end else begin
      tens  = 2'd0;
      units = shown_d[3:0];
    end
    disp_on = busy_d && !(ann_d && tog_d[0]);
    seg_d   = 7'h00;
    an_d    = 2'b00;
    if (disp_on) begin
      an_d = digit_d ? 2'b10 : 2'b01;
      if (digit_d) seg_d = (tens == 2'd0) ? 7'h00 : seg_code({2'b00, tens});
      else         seg_d = seg_code(units);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cap_q      <= '0;
      wv_q       <= 1'b0;
      for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
      hist_vld_q <= '0;
      blink_q    <= '0;
      tog_q      <= '0;
      mux_q      <= '0;
      digit_q    <= 1'b0;
      shown_id   <= '0;
      busy       <= 1'b0;
      announcing <= 1'b0;
      reject     <= 1'b0;
      hist_count <= '0;
      seg        <= '0;
      an         <= 2'b00;
    end else begin
      state_q    <= state_d;
      cap_q      <= cap_d;
      wv_q       <= win_valid;
      hist_q     <= hist_d;
      hist_vld_q <= hist_vld_d;
      blink_q    <= blink_d;
      tog_q      <= tog_d;
      mux_q      <= mux_d;
      digit_q    <= digit_d;
      shown_id   <= shown_d;
      busy       <= busy_d;
      announcing <= ann_d;
      reject     <= reject_d;
      hist_count <= count_d;
      seg        <= seg_d;
      an         <= an_d;
    end
  end

endmodule

// File: tb/tb_winner_announcer.sv
// Scoreboard bench for winner_announcer: a history model predicts accept/reject per draw,
// a monitor pops predictions when the DUT reports a result.
module tb_winner_announcer;

  localparam int BLINK_HALF    = 4;
  localparam int BLINK_TOGGLES = 6;

  logic       clk, reset;
  logic [4:0] winner, entries;
  logic       win_valid, ack, clear_hist;
  logic [4:0] shown_id;
  logic       busy, announcing, reject;
  logic [2:0] hist_count;
  logic [6:0] seg;
  logic [1:0] an;

  typedef struct packed {
    logic       rej;
    logic [4:0] id;
  } sb_item_t;

  sb_item_t   sb [$];
  int         hist_m [$];
  int         compared = 0;
  int         mismatched = 0;
  logic [4:0] prev_shown = 5'd0;
  logic [6:0] enc [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  winner_announcer dut (
    .clk(clk), .reset(reset), .winner(winner), .win_valid(win_valid), .entries(entries),
    .ack(ack), .clear_hist(clear_hist), .shown_id(shown_id), .busy(busy),
    .announcing(announcing), .reject(reject), .hist_count(hist_count), .seg(seg), .an(an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit modelAccept(input logic [4:0] id);
    if ($isunknown(id) || id == 5'd0 || id >= entries) return 1'b0;
    foreach (hist_m[i]) if (hist_m[i] == int'(id)) return 1'b0;
    hist_m.push_front(int'(id));
    if (hist_m.size() > 4) void'(hist_m.pop_back());
    return 1'b1;
  endfunction

  // Result monitor: a reject pulse or a freshly shown id consumes one prediction.
  always @(negedge clk) begin
    if (reject || (shown_id != 5'd0 && prev_shown == 5'd0)) begin
      if (sb.size() == 0) checkOutput("sb_unexpected", {26'd0, reject, shown_id}, 32'd0);
      else begin
        sb_item_t e;
        e = sb.pop_front();
        checkOutput("sb_result", {26'd0, reject, shown_id}, {26'd0, e.rej, e.id});
      end
    end
    prev_shown = shown_id;
  end

  task automatic applyStimulus(input logic [4:0] id, input bit clr, input bit noise);
    sb_item_t e;
    bit       acc;
    int       k, tens_e, units_e;
    @(negedge clk);
    if (clr) hist_m.delete();
    acc   = modelAccept(id);
    e.rej = !acc;
    e.id  = acc ? id : 5'd0;
    sb.push_back(e);
    winner     = id;
    win_valid  = 1'b1;
    clear_hist = clr;
    @(negedge clk);
    clear_hist = 1'b0;
    checkOutput("busy_in_check", busy, 1);
    @(negedge clk);
    win_valid = 1'b0;
    if (!acc) begin
      checkOutput("busy_after_reject", busy, 0);
      checkOutput("hist_count", hist_count, hist_m.size());
      return;
    end
    k = 0;
    while (announcing && k < 200) begin
      checkOutput("blink_phase", an != 2'b00, ((k / BLINK_HALF) % 2) == 0);
      if (noise && k == 2) ack = 1'b1;
      if (noise && k == 5) ack = 1'b0;
      k++;
      @(negedge clk);
    end
    checkOutput("announce_len", k, BLINK_HALF * BLINK_TOGGLES);
    checkOutput("busy_hold", busy, 1);
    if (noise) begin
      winner    = 5'd9;
      win_valid = 1'b1;
    end
    tens_e  = int'(id) / 10;
    units_e = int'(id) % 10;
    for (int j = 0; j < 4; j++) begin
      checkOutput("an_onehot", (an == 2'b01) || (an == 2'b10), 1);
      if (an == 2'b10) checkOutput("seg_tens", seg, (tens_e == 0) ? 7'h00 : enc[tens_e]);
      else             checkOutput("seg_units", seg, enc[units_e]);
      @(negedge clk);
    end
    checkOutput("shown_hold", shown_id, id);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    checkOutput("shown_after_ack", shown_id, 0);
    checkOutput("busy_after_ack", busy, 0);
    checkOutput("hist_count", hist_count, hist_m.size());
    if (noise) begin
      @(negedge clk);
      @(negedge clk);
      checkOutput("stale_edge_dropped", busy, 0);
      win_valid = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sb_item_t e;
    reset      = 1'b0;
    winner     = 5'd0;
    win_valid  = 1'b0;
    entries    = 5'd10;
    ack        = 1'b0;
    clear_hist = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_shown", shown_id, 0);
    checkOutput("rst_busy", {busy, announcing, reject}, 0);
    checkOutput("rst_disp", {seg, an}, 0);
    reset = 1'b1;

    applyStimulus(5'd7, 1'b0, 1'b0);
    applyStimulus(5'd12, 1'b0, 1'b0);
    applyStimulus(5'd10, 1'b0, 1'b0);
    applyStimulus(5'd0, 1'b0, 1'b0);
    applyStimulus(5'bx, 1'b0, 1'b0);
    applyStimulus(5'd7, 1'b0, 1'b0);

    @(negedge clk);
    clear_hist = 1'b1;
    hist_m.delete();
    @(negedge clk);
    clear_hist = 1'b0;
    checkOutput("hist_cleared", hist_count, 0);
    applyStimulus(5'd7, 1'b0, 1'b0);
    applyStimulus(5'd7, 1'b1, 1'b0);

    applyStimulus(5'd1, 1'b1, 1'b0);
    for (int i = 2; i <= 5; i++) applyStimulus(5'(i), 1'b0, 1'b0);
    checkOutput("hist_saturated", hist_count, 4);
    applyStimulus(5'd1, 1'b0, 1'b0);
    applyStimulus(5'd5, 1'b0, 1'b0);

    entries = 5'd30;
    applyStimulus(5'd23, 1'b0, 1'b1);

    @(negedge clk);
    e.rej = !modelAccept(5'd3);
    e.id  = e.rej ? 5'd0 : 5'd3;
    sb.push_back(e);
    winner    = 5'd3;
    win_valid = 1'b1;
    repeat (2) @(negedge clk);
    win_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("pre_reset_announcing", announcing, 1);
    reset = 1'b0;
    hist_m.delete();
    @(negedge clk);
    checkOutput("midrst_shown", shown_id, 0);
    checkOutput("midrst_flags", {busy, announcing, reject}, 0);
    checkOutput("midrst_hist", hist_count, 0);
    checkOutput("midrst_disp", {seg, an}, 0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("postrst_idle", busy, 0);
    applyStimulus(5'd3, 1'b0, 1'b0);

    @(negedge clk);
    checkOutput("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
